// File: rtl/alu_cmp_pkg.sv
// Shared constants for the ALU compare path: FSM states, nibble width and
// the result codes handed to the flag register.
package alu_cmp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } cmp_state_t;

  // CMP_NONE only exists between reset and the first completed compare.
  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_EQ   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_GT   = 2'b11;

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit unsigned compare; greater-than is left to the caller
// as !eq & !lt.
module nibble_cmp
  import alu_cmp_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/serial_magnitude_compare.sv
// Nibble-serial magnitude comparator, MSB nibble first, with early exit on the
// first unequal nibble. Define CMP_SIGNED_EN for two's-complement operands.
module serial_magnitude_compare
  import alu_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NIB - 1);

  cmp_state_t        r_state;
  cmp_state_t        w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDX_W-1:0]  r_idx;
  logic              r_done;
  logic [1:0]        r_res;

  logic              w_accept;
  logic              w_finish;
  logic [NIB_W-1:0]  w_a_nib;
  logic [NIB_W-1:0]  w_b_nib;
  logic [NIB_W-1:0]  w_a_op;
  logic [NIB_W-1:0]  w_b_op;
  logic              w_nib_eq;
  logic              w_nib_lt;
  logic              w_nib_gt;
  logic [1:0]        w_res_nxt;

  assign w_a_nib = r_a[int'(r_idx)*NIB_W +: NIB_W];
  assign w_b_nib = r_b[int'(r_idx)*NIB_W +: NIB_W];

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit on the top nibble maps two's complement onto
  // unsigned order; lower nibbles are plain magnitude.
  logic w_msb_step;
  assign w_msb_step = (r_idx == IDX_MAX);
  assign w_a_op = w_msb_step ? {~w_a_nib[NIB_W-1], w_a_nib[NIB_W-2:0]} : w_a_nib;
  assign w_b_op = w_msb_step ? {~w_b_nib[NIB_W-1], w_b_nib[NIB_W-2:0]} : w_b_nib;
`else
  assign w_a_op = w_a_nib;
  assign w_b_op = w_b_nib;
`endif

  nibble_cmp u_nibble_cmp (
    .i_a  (w_a_op),
    .i_b  (w_b_op),
    .o_eq (w_nib_eq),
    .o_lt (w_nib_lt)
  );

  assign w_nib_gt  = !w_nib_eq & !w_nib_lt;
  assign w_res_nxt = w_nib_lt ? CMP_LT : (w_nib_gt ? CMP_GT : CMP_EQ);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_accept    = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!w_nib_eq || (r_idx == '0)) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result holds its last value across a new compare until that one finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_res  <= CMP_NONE;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_idx <= IDX_MAX;
      end else if ((r_state == ST_SCAN) && !w_finish) begin
        r_idx <= r_idx - 1'b1;
      end
      if (w_finish) r_res <= w_res_nxt;
    end
  end

  assign busy = (r_state == ST_SCAN);
  assign done = r_done;
  assign eq   = (r_res == CMP_EQ);
  assign lt   = (r_res == CMP_LT);
  assign gt   = (r_res == CMP_GT);

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Directed bench for serial_magnitude_compare (WIDTH=16) with a result
// scoreboard; expectations come from a behavioural compare model.
module tb_serial_magnitude_compare;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        eq;
  logic        lt;
  logic        gt;

  serial_magnitude_compare #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;   // {eq, lt, gt}
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input string tag);
    exp_t e;
    bit   found;
    found = 1'b0;
    e.lat = 4;
    for (int k = 0; k < 4; k++) begin
      if (!found && (x[15-4*k -: 4] != y[15-4*k -: 4])) begin
        found = 1'b1;
        e.lat = k + 1;
      end
    end
`ifdef CMP_SIGNED_EN
    if ($signed(x) < $signed(y))      e.flags = 3'b010;
    else if ($signed(x) > $signed(y)) e.flags = 3'b001;
    else                              e.flags = 3'b100;
`else
    if (x < y)      e.flags = 3'b010;
    else if (x > y) e.flags = 3'b001;
    else            e.flags = 3'b100;
`endif
    e.tag = tag;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge E0.
  task automatic drive_start(input logic [15:0] x, input logic [15:0] y, input string tag);
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(model(x, y, tag));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_E0"}, busy, 1);
    check({tag, "_no_done_E0"}, done, 0);
  endtask

  // Returns at the negedge of the done cycle; busy_cycles includes the E0 cycle.
  task automatic wait_done(output int busy_cycles);
    int   lat;
    exp_t e;
    lat         = 0;
    busy_cycles = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busy_cycles++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_done"}, done, 1);
      check({e.tag, "_flags"}, {eq, lt, gt}, e.flags);
      check({e.tag, "_latency"}, lat, e.lat);
      check({e.tag, "_busy_low_at_done"}, busy, 0);
    end
  endtask

  initial begin
    int          bc;
    bit          seen;
    logic [15:0] x;
    logic [15:0] y;
    int          p;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset for two cycles, then idle with start low.
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, eq, lt, gt}, 0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("idle_no_done", seen, 0);
    check("idle_flags_zero", {eq, lt, gt}, 0);

    // Equal operands: full scan.
    drive_start(16'h1234, 16'h1234, "eq_full");
    wait_done(bc);
    check("eq_full_busy_cycles", bc, 4);
    @(negedge clk);
    check("done_single_pulse", done, 0);

    // Early exits.
    drive_start(16'h0FFF, 16'h1000, "lt_early");
    wait_done(bc);
    @(negedge clk);
    drive_start(16'h12A4, 16'h1294, "gt_early");
    wait_done(bc);
    @(negedge clk);

    // Start while busy must be ignored.
    drive_start(16'h5555, 16'h5555, "busy_ignore");
    a     = 16'h0000;
    b     = 16'hFFFF;
    start = 1'b1;
    wait_done(bc);
    @(negedge clk);
    check("busy_ignore_no_restart", {busy, done}, 0);

    // Back-to-back: start presented in the done cycle.
    drive_start(16'h00F0, 16'h00F0, "pre_b2b");
    wait_done(bc);
    drive_start(16'h0001, 16'h0002, "b2b");
    wait_done(bc);
    @(negedge clk);

    // Reset in the middle of a compare: no done, outputs cleared.
    drive_start(16'hABCD, 16'hABCD, "rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, eq, lt, gt}, 0);
    rst = 1'b0;
    void'(sb.pop_back());
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rst_mid_no_done", seen, 0);
    drive_start(16'h0001, 16'h0000, "after_rst");
    wait_done(bc);
    @(negedge clk);

    // Sign bit in the top nibble.
    drive_start(16'h8000, 16'h0001, "signed_msb");
    wait_done(bc);
    @(negedge clk);

    // Randomised operands that differ in a chosen nibble (or not at all).
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom);
      p = $urandom_range(0, 4);
      y = x;
      if (p < 4) y = x ^ (16'($urandom_range(1, 15)) << (4 * p));
      drive_start(x, y, $sformatf("rand%0d", i));
      wait_done(bc);
      @(negedge clk);
    end

    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
